// File: rtl/screen_fill_engine.sv
// -----------------------------------------------------------------------------
// screen_fill_engine
//
// Frame-clear pixel generator. One accepted request makes the engine emit
// every pixel coordinate of a WIDTH x HEIGHT screen in row-major order,
// each tagged with the fill color, over a valid/ready stream.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous, active-high reset
//   fill_color   12-bit fill color, passed straight through to out_color
//   in_valid     fill request
//   in_ready     engine idle and able to accept a request
//   busy         fill in progress
//   out_pixel_x  current pixel column
//   out_pixel_y  current pixel row
//   out_color    color of the current pixel
//   out_valid    pixel presented
//   out_ready    downstream accepts the presented pixel
// -----------------------------------------------------------------------------
module screen_fill_engine #(
   parameter int unsigned WIDTH  = 320,
   parameter int unsigned HEIGHT = 240
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] fill_color,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        busy,
   output logic [15:0] out_pixel_x,
   output logic [15:0] out_pixel_y,
   output logic [11:0] out_color,
   output logic        out_valid,
   input  logic        out_ready
);

   localparam logic [15:0] X_LAST = 16'(WIDTH - 1);
   localparam logic [15:0] Y_LAST = 16'(HEIGHT - 1);

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] x_q, x_d;
   logic [15:0] y_q, y_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      unique case (state_q)
         IDLE: begin
            // Counters already sit at zero here, so the first pixel after
            // acceptance is (0,0) without any extra setup cycle.
            x_d = '0;
            y_d = '0;
            if (in_valid) state_d = FILL;
         end
         FILL: begin
            if (out_ready) begin
               if (x_q == X_LAST) begin
                  x_d = '0;
                  if (y_q == Y_LAST) begin
                     // Last pixel transferred: park counters for the next frame.
                     y_d     = '0;
                     state_d = IDLE;
                  end else begin
                     y_d = y_q + 16'd1;
                  end
               end else begin
                  x_d = x_q + 16'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // All handshake outputs come from state alone, so out_valid never
   // depends combinationally on out_ready.
   assign in_ready    = (state_q == IDLE);
   assign busy        = (state_q == FILL);
   assign out_valid   = (state_q == FILL);
   assign out_pixel_x = x_q;
   assign out_pixel_y = y_q;
   assign out_color   = fill_color;

endmodule

// File: tb/tb_screen_fill_engine.sv
module tb_screen_fill_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] fill_color;
   logic        in_valid;
   logic        in_ready;
   logic        busy;
   logic [15:0] px, py;
   logic [11:0] oc;
   logic        ov;
   logic        ordy;

   logic        in_valid2;
   logic        in_ready2;
   logic        busy2;
   logic [15:0] px2, py2;
   logic [11:0] oc2;
   logic        ov2;
   logic        ordy2;

   int total = 0;
   int bad   = 0;
   int accepts = 0;

   logic [43:0] sb[$];

   always #5 clk = ~clk;

   screen_fill_engine #(.WIDTH(4), .HEIGHT(3)) dut (
      .clk(clk), .rst(rst), .fill_color(fill_color), .in_valid(in_valid),
      .in_ready(in_ready), .busy(busy), .out_pixel_x(px), .out_pixel_y(py),
      .out_color(oc), .out_valid(ov), .out_ready(ordy)
   );

   screen_fill_engine dut_big (
      .clk(clk), .rst(rst), .fill_color(fill_color), .in_valid(in_valid2),
      .in_ready(in_ready2), .busy(busy2), .out_pixel_x(px2), .out_pixel_y(py2),
      .out_color(oc2), .out_valid(ov2), .out_ready(ordy2)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle of the small DUT: sample outputs before the edge,
   // score any transfer, push expectations for an accepted request.
   task automatic cyc();
      logic [43:0] e;
      chk("busy_eq_valid", {63'd0, busy}, {63'd0, ov});
      chk("ready_eq_idle", {63'd0, in_ready}, {63'd0, ~busy});
      chk("color_pass", {52'd0, oc}, {52'd0, fill_color});
      if (rst) begin
         sb.delete();
      end else begin
         if (ov && ordy) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               chk("pixel", {20'd0, px, py, oc}, {20'd0, e});
            end
         end
         if (in_valid && in_ready) begin
            accepts++;
            for (int yy = 0; yy < 3; yy++)
               for (int xx = 0; xx < 4; xx++)
                  sb.push_back({16'(xx), 16'(yy), fill_color});
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int bcnt, n, errs, guard;
      logic [15:0] hx, hy, ex, ey, lx, ly;
      logic hb, stall;
      bit [3:0] pat;

      rst = 1'b1; in_valid = 1'b1; fill_color = 12'h000; ordy = 1'b1;
      in_valid2 = 1'b0; ordy2 = 1'b1;
      @(posedge clk);
      #1;

      // Reset held with a pending request
      for (int i = 0; i < 3; i++) begin
         chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
         chk("rst_busy", {63'd0, busy}, 64'd0);
         chk("rst_valid", {63'd0, ov}, 64'd0);
         chk("rst_xy", {32'd0, px, py}, 64'd0);
         cyc();
      end
      rst = 1'b0; in_valid = 1'b0;
      cyc();
      chk("no_fill_after_rst", {63'd0, busy}, 64'd0);

      // Full small frame, no stalls
      fill_color = 12'hABC; ordy = 1'b1; in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      chk("start_xy", {32'd0, px, py}, 64'd0);
      bcnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (busy) bcnt++;
         cyc();
      end
      chk("busy_cycles", 64'(bcnt), 64'd12);
      chk("idle_after", {63'd0, in_ready}, 64'd1);
      chk("sb_empty_full", 64'(sb.size()), 64'd0);

      // Backpressure pattern 1,0,0,1
      fill_color = 12'h5A3; pat = 4'b1001; in_valid = 1'b1; ordy = 1'b1;
      cyc();
      in_valid = 1'b0;
      guard = 0;
      while (busy && guard < 100) begin
         ordy = pat[guard % 4];
         stall = ov && !ordy; hx = px; hy = py; hb = busy;
         cyc();
         if (stall) chk("bp_hold", {31'd0, px, py, busy}, {31'd0, hx, hy, hb});
         guard++;
      end
      chk("bp_done", {63'd0, busy}, 64'd0);
      chk("sb_empty_bp", 64'(sb.size()), 64'd0);
      ordy = 1'b1;

      // Continuous request: exactly one fill, one idle cycle, second fill
      fill_color = 12'h3C7; accepts = 0; in_valid = 1'b1;
      cyc();
      repeat (12) cyc();
      chk("gap_busy", {63'd0, busy}, 64'd0);
      chk("gap_ready", {63'd0, in_ready}, 64'd1);
      chk("one_accept", 64'(accepts), 64'd1);
      cyc();
      in_valid = 1'b0;
      chk("restart_xy", {31'd0, px, py, busy}, 64'd1);
      guard = 0;
      while (busy && guard < 30) begin cyc(); guard++; end
      chk("two_accepts", 64'(accepts), 64'd2);
      chk("sb_empty_cont", 64'(sb.size()), 64'd0);

      // Reset mid-fill after pixel (2,1) transfers
      fill_color = 12'h0F0; in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      repeat (7) cyc();
      chk("pre_abort_xy", {32'd0, px, py}, {32'd0, 16'd3, 16'd1});
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("abort_busy", {63'd0, busy}, 64'd0);
      chk("abort_valid", {63'd0, ov}, 64'd0);
      chk("abort_xy", {32'd0, px, py}, 64'd0);
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      chk("after_abort_xy", {31'd0, px, py, busy}, 64'd1);
      guard = 0;
      while (busy && guard < 30) begin cyc(); guard++; end
      chk("sb_empty_abort", 64'(sb.size()), 64'd0);

      // Default 320x240 frame
      in_valid2 = 1'b1;
      @(posedge clk);
      #1;
      in_valid2 = 1'b0;
      chk("big_start", {63'd0, busy2}, 64'd1);
      n = 0; errs = 0; ex = 0; ey = 0; lx = 0; ly = 0; guard = 0;
      while (busy2 && guard < 80000) begin
         if (ov2) begin
            if (px2 !== ex || py2 !== ey) errs++;
            lx = px2; ly = py2; n++;
            if (ex == 16'd319) begin ex = 0; ey = ey + 16'd1; end
            else ex = ex + 16'd1;
         end
         @(posedge clk);
         #1;
         guard++;
      end
      chk("big_count", 64'(n), 64'd76800);
      chk("big_order_errs", 64'(errs), 64'd0);
      chk("big_last", {32'd0, lx, ly}, {32'd0, 16'd319, 16'd239});
      chk("big_idle", {61'd0, busy2, ov2, in_ready2}, 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
